// File: rtl/mac_out_stage.sv
// Output conditioning stage for the MAC result: round, shift and saturate to a
// signed sample, then buffer it in a small FIFO behind a ready/valid handshake.
module mac_out_stage #(
    parameter int IN_W  = 28,
    parameter int OUT_W = 16,
    parameter int SHIFT = 12,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  f_in,
    input  logic                    valid_in,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overflow,
    output logic [7:0]              sat_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = OUT_W + 1;

    localparam logic signed [IN_W:0] RND     = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [IN_W:0]  ext_s;
    logic signed [IN_W:0]  rnd_s;
    logic signed [IN_W:0]  shf_s;
    logic [OUT_W-1:0]      q_data_s;
    logic                  q_sat_s;

    logic [EW-1:0]         mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [OUT_W-1:0]      out_data_r;
    logic                  out_sat_r;
    logic                  out_valid_r;
    logic                  overflow_r;
    logic [7:0]            sat_count_r;

    logic                  full_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic [CW-1:0]         count_nx_s;
    logic [AW-1:0]         rd_nx_s;
    logic [EW-1:0]         head_nx_s;

    // Quantizer: round half toward +inf, arithmetic shift, clip to the output range.
    always_comb begin
        ext_s = {f_in[IN_W-1], f_in};
        rnd_s = ext_s + RND;
        shf_s = rnd_s >>> SHIFT;
        if (shf_s > SAT_MAX) begin
            q_data_s = {1'b0, {(OUT_W - 1){1'b1}}};
            q_sat_s  = 1'b1;
        end else if (shf_s < SAT_MIN) begin
            q_data_s = {1'b1, {(OUT_W - 1){1'b0}}};
            q_sat_s  = 1'b1;
        end else begin
            q_data_s = shf_s[OUT_W-1:0];
            q_sat_s  = 1'b0;
        end
    end

    // FIFO control decode and next head selection.
    always_comb begin
        full_s  = (count_r == CW'(DEPTH));
        pop_s   = out_valid_r & out_ready;
        push_s  = valid_in & (~full_s | pop_s);
        drop_s  = valid_in & full_s & ~pop_s;
        rd_nx_s = pop_s ? (rd_ptr_r + AW'(1'b1)) : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_nx_s = count_r + CW'(1'b1);
            2'b01:   count_nx_s = count_r - CW'(1'b1);
            default: count_nx_s = count_r;
        endcase
        // The slot becoming head may be the one written on this same edge.
        if (push_s && (wr_ptr_r == rd_nx_s)) begin
            head_nx_s = {q_sat_s, q_data_s};
        end else begin
            head_nx_s = mem_r[rd_nx_s];
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {q_sat_s, q_data_s};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, occupancy, registered head outputs and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            out_data_r  <= {OUT_W{1'b0}};
            out_sat_r   <= 1'b0;
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            sat_count_r <= 8'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            rd_ptr_r    <= rd_nx_s;
            count_r     <= count_nx_s;
            out_valid_r <= (count_nx_s != {CW{1'b0}});
            if (count_nx_s != {CW{1'b0}}) begin
                {out_sat_r, out_data_r} <= head_nx_s;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (push_s && q_sat_s && (sat_count_r != 8'hFF)) begin
                sat_count_r <= sat_count_r + 8'd1;
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_sat   = out_sat_r;
    assign out_valid = out_valid_r;
    assign overflow  = overflow_r;
    assign sat_count = sat_count_r;

endmodule
